// File: rtl/div_seq_mnbit.sv
// div_seq_mnbit -- sequential restoring divider, one quotient bit per clock.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        begin a division (sampled in IDLE only)
//   A [M-1:0]    unsigned dividend
//   B [N-1:0]    unsigned divisor
//   Quot [M-1:0] unsigned quotient, registered, updated on entry to DONE
//   Rem [N-1:0]  unsigned remainder, registered, updated on entry to DONE
//   busy         high while the iterations run
//   done         one-cycle pulse, Quot/Rem/div_by_zero valid
//   div_by_zero  latched divisor was zero (Quot = all ones, Rem = 0)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; operands latched on the accepting edge
// S_CALC | M restoring steps, dividend MSB first
// S_DONE | result registers valid, done pulse, back to S_IDLE

module div_seq_mnbit #(
   parameter int M = 4,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [M-1:0] A,
   input  logic [N-1:0] B,
   output logic [M-1:0] Quot,
   output logic [N-1:0] Rem,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero
);

   localparam int CW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t         state_q;
   logic [M-1:0]   dvd_q;    // dividend bits shift out the top, quotient bits in at the bottom
   logic [N-1:0]   dvs_q;
   logic [N:0]     prem_q;
   logic [CW-1:0]  cnt_q;
   logic [M-1:0]   quot_q;
   logic [N-1:0]   rem_q;
   logic           busy_q;
   logic           done_q;
   logic           dbz_q;

   logic [N+1:0]   diff_d;
   logic           qbit_d;
   logic [N:0]     prem_d;
   logic [M-1:0]   dvd_d;

   // The partial remainder stays below the divisor, so the shifted value
   // fits in N+1 bits; one extra bit on the difference carries the sign.
   always_comb begin
      diff_d = {prem_q, dvd_q[M-1]} - {2'b00, dvs_q};
      qbit_d = ~diff_d[N+1];
      prem_d = qbit_d ? diff_d[N:0] : {prem_q[N-1:0], dvd_q[M-1]};
      dvd_d  = {dvd_q[M-2:0], qbit_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  dvd_q  <= A;
                  dvs_q  <= B;
                  prem_q <= '0;
                  cnt_q  <= CW'(M - 1);
                  if (B == '0) begin
                     state_q <= S_DONE;
                     quot_q  <= '1;
                     rem_q   <= '0;
                     dbz_q   <= 1'b1;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_CALC;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               dvd_q  <= dvd_d;
               prem_q <= prem_d;
               cnt_q  <= cnt_q - CW'(1);
               // Terminal count: this step produces the last quotient bit,
               // so load the result registers straight from the step logic.
               if (cnt_q == '0) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  quot_q  <= dvd_d;
                  rem_q   <= prem_d[N-1:0];
                  dbz_q   <= 1'b0;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Quot        = quot_q;
   assign Rem         = rem_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule
